// File: rtl/latency_catch_fifo.sv
// rtl/latency_catch_fifo.sv - credit-issuing catch FIFO behind a fixed-latency pipeline
// Optional latency checker enabled by defining LATENCY_CHECK_EN (adds err_latency output).
module latency_catch_fifo #(
    parameter int DW    = 16,
    parameter int LAT   = 2,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic          pipe_valid,
    input  logic [DW-1:0] pipe_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] level
`ifdef LATENCY_CHECK_EN
    ,
    output logic          err_latency
`endif
);

    localparam int PW  = $clog2(DEPTH);
    localparam int DCW = $clog2(LAT + 1);

    typedef enum logic [1:0] {S_RESET, S_DRAIN, S_RUN} state_t;

    state_t           state, state_next;
    logic [DCW-1:0]   drain_cnt;
    logic             drain;
    logic [CW-1:0]    count, inflight;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [DW-1:0]    mem [DEPTH];
    logic [CW:0]      committed;
    logic             launch, arrive, pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RESET;
            drain_cnt <= DCW'(LAT);
        end else begin
            state <= state_next;
            if (drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // State leaves DRAIN on the same edge drain_cnt reaches zero.
    always_comb begin
        state_next = state;
        drain      = 1'b1;
        case (state)
            S_RESET: state_next = (drain_cnt <= DCW'(1)) ? S_RUN : S_DRAIN;
            S_DRAIN: if (drain_cnt == DCW'(1)) state_next = S_RUN;
            S_RUN:   drain = 1'b0;
            default: state_next = S_RESET;
        endcase
    end

    assign committed   = {1'b0, count} + {1'b0, inflight};
    assign issue_ready = !rst && !drain && (committed < (CW+1)'(DEPTH));
    assign launch      = issue_valid && issue_ready;
    // A strobe with nothing in flight cannot be ours; dropping it keeps the credit count honest.
    assign arrive      = pipe_valid && !drain && (inflight != '0);
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    assign out_data    = mem[rd_ptr];
    assign level       = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            case ({launch, arrive})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            case ({arrive, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (arrive) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arrive && !rst)
            mem[wr_ptr] <= pipe_data;
    end

`ifdef LATENCY_CHECK_EN
    logic [LAT-1:0] launch_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            launch_sr   <= '0;
            err_latency <= 1'b0;
        end else begin
            launch_sr[0] <= launch;
            for (int i = 1; i < LAT; i++)
                launch_sr[i] <= launch_sr[i-1];
            if (state == S_RUN && pipe_valid != launch_sr[LAT-1])
                err_latency <= 1'b1;
        end
    end
`endif

endmodule
